// File: rtl/simple_box_pkg.sv
// Shared types and default geometry for the streaming bounding-box detector.
// The box struct layout matches the packed read-back word.
package simple_box_pkg;

  localparam int WIDTH         = 100;
  localparam int HEIGHT        = 100;
  localparam int THRESHOLD     = 128;
  localparam int RESTART_INDEX = 99999;

  typedef logic [7:0] coord_t;

  typedef struct packed {
    coord_t xMin;
    coord_t yMin;
    coord_t xMax;
    coord_t yMax;
  } box_t;

endpackage

// File: rtl/box_addr_decode.sv
// Splits a byte index into pixel coordinates and colour channel.
// Purely combinational; the divisors are constants, so this reduces to fixed logic.
module box_addr_decode
  import simple_box_pkg::*;
#(
  parameter int WIDTH  = simple_box_pkg::WIDTH,
  parameter int HEIGHT = simple_box_pkg::HEIGHT
) (
  input  logic [23:0] idx_i,
  output logic        valid_o,
  output coord_t      x_o,
  output coord_t      y_o,
  output logic [1:0]  chan_o
);

  logic [23:0] pixel;

  assign pixel   = idx_i / 24'd3;
  assign chan_o  = 2'(idx_i % 24'd3);
  assign x_o     = coord_t'(pixel % 24'(WIDTH));
  assign y_o     = coord_t'(pixel / 24'(WIDTH));
  assign valid_o = idx_i < 24'(WIDTH * HEIGHT * 3);

endmodule

// File: rtl/simple_box.sv
// Streaming bounding-box detector: folds each pixel's R,G,B bytes into a channel
// minimum and grows the box around every pixel whose darkest channel is below threshold.
module simple_box
  import simple_box_pkg::*;
#(
  parameter int WIDTH         = simple_box_pkg::WIDTH,
  parameter int HEIGHT        = simple_box_pkg::HEIGHT,
  parameter int THRESHOLD     = simple_box_pkg::THRESHOLD,
  parameter int RESTART_INDEX = simple_box_pkg::RESTART_INDEX
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] hex_value_index,
  output logic [31:0] out
);

  logic [23:0] idx;
  logic [7:0]  data;
  logic        pixValid;
  coord_t      pixX;
  coord_t      pixY;
  logic [1:0]  chan;

  assign idx  = hex_value_index[23:0];
  assign data = hex_value_index[31:24];

  box_addr_decode #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) uDecode (
    .idx_i  (idx),
    .valid_o(pixValid),
    .x_o    (pixX),
    .y_o    (pixY),
    .chan_o (chan)
  );

  coord_t      xMin, yMin, xMax, yMax;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  chanMin;
  logic [31:0] out_q;
  logic        restart;
  logic        pixWrite;
  logic        isFg;
  box_t        boxNow;

  assign restart  = idx == 24'(RESTART_INDEX);
  assign pixWrite = wr_en && pixValid;
  assign chanMin  = (data < acc_q) ? data : acc_q;
  assign isFg     = {1'b0, chanMin} < 9'(THRESHOLD);
  assign boxNow   = '{xMin: xMin, yMin: yMin, xMax: xMax, yMax: yMax};
  assign out      = out_q;

  // The accumulator carries the running channel minimum across the R and G bytes.
  always_comb begin
    acc_d = acc_q;
    if (restart) begin
      acc_d = 8'hFF;
    end else if (pixWrite) begin
      if (chan == 2'd0) acc_d = data;
      else if (chan == 2'd1) acc_d = chanMin;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset_n) begin
      xMin  <= coord_t'(WIDTH - 1);
      yMin  <= coord_t'(HEIGHT - 1);
      xMax  <= '0;
      yMax  <= '0;
      acc_q <= 8'hFF;
      out_q <= '0;
    end else begin
      // Reads see the box as it stood before this edge's update.
      if (rd_en) out_q <= boxNow;
      acc_q <= acc_d;
      if (restart) begin
        xMin <= coord_t'(WIDTH - 1);
        yMin <= coord_t'(HEIGHT - 1);
        xMax <= '0;
        yMax <= '0;
      end else if (pixWrite && chan == 2'd2 && isFg) begin
        if (pixX < xMin) xMin <= pixX;
        if (pixX > xMax) xMax <= pixX;
        if (pixY < yMin) yMin <= pixY;
        if (pixY > yMax) yMax <= pixY;
      end
    end
  end

endmodule

// File: tb/tb_simple_box.sv
// Self-checking bench for simple_box: expected boxes are queued as stimulus is
// driven and popped when the DUT state is sampled on the falling edge.
module tb_simple_box;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] hex_value_index;
  logic [31:0] out;

  int vectorCount = 0;
  int missCount   = 0;
  logic [31:0] sbQ[$];

  simple_box dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .rd_en          (rd_en),
    .wr_en          (wr_en),
    .hex_value_index(hex_value_index),
    .out            (out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [31:0] boxRegs();
    return {dut.xMin, dut.yMin, dut.xMax, dut.yMax};
  endfunction

  task automatic driveIdle();
    @(negedge CLOCK_50);
    reset_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    hex_value_index = 32'd30000;
  endtask

  task automatic writeByte(input int idx, input logic [7:0] data, input logic wr, input logic rd);
    @(negedge CLOCK_50);
    reset_n = 1'b0; wr_en = wr; rd_en = rd;
    hex_value_index = {data, 24'(idx)};
  endtask

  task automatic writePixel(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
    int base;
    base = 3 * (y * 100 + x);
    writeByte(base, r, 1'b1, 1'b0);
    writeByte(base + 1, g, 1'b1, 1'b0);
    writeByte(base + 2, b, 1'b1, 1'b0);
  endtask

  function automatic bit triFg(int x, int y);
    return y >= 34 && y <= 78 && x >= 28 && x <= 69 && (x - 28) <= (y - 34);
  endfunction

  function automatic bit shapeFg(int x, int y);
    return (x >= 4 && x <= 40 && y >= 16 && y <= 30) || (x >= 60 && x <= 84 && y >= 50 && y <= 77);
  endfunction

  // Foreground pixels put a dark value (0x7F or 0x00) in a rotating channel;
  // background pixels put exactly 0x80 in a rotating channel so they sit on the threshold.
  task automatic streamImage(input bit useShape);
    logic [7:0] ch[3];
    bit fg;
    for (int p = 0; p < 10000; p++) begin
      int x, y, k;
      x = p % 100; y = p / 100; k = (x + y) % 3;
      fg = useShape ? shapeFg(x, y) : triFg(x, y);
      for (int c = 0; c < 3; c++) ch[c] = fg ? 8'hFF : 8'hC0;
      ch[k] = fg ? ((x % 2 == 1) ? 8'h7F : 8'h00) : 8'h80;
      for (int c = 0; c < 3; c++) writeByte(3 * p + c, ch[c], 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    @(negedge CLOCK_50);
    reset_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; hex_value_index = 32'd30000;
    sbQ.push_back(32'h6363_0000);
    sbQ.push_back(32'h0000_0000);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL reset_box: got %h expected %h", boxRegs(), exp);
    end
    exp = sbQ.pop_front(); vectorCount++;
    if (out !== exp) begin
      missCount++; $display("[TB] FAIL reset_out: got %h expected %h", out, exp);
    end
  endtask

  task automatic test_triangle();
    logic [31:0] exp;
    streamImage(1'b0);
    sbQ.push_back(32'h1C22_454E);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL triangle_box: got %h expected %h", boxRegs(), exp);
    end
  endtask

  task automatic test_restart_shape();
    logic [31:0] exp;
    writeByte(99999, 8'h00, 1'b0, 1'b0);
    sbQ.push_back(32'h6363_0000);
    writeByte(100000, 8'h00, 1'b1, 1'b0);
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL restart_clear: got %h expected %h", boxRegs(), exp);
    end
    sbQ.push_back(32'h6363_0000);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL idx_100000_ignored: got %h expected %h", boxRegs(), exp);
    end
    streamImage(1'b1);
    sbQ.push_back(32'h0410_544D);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL shape_box: got %h expected %h", boxRegs(), exp);
    end
    writeByte(30000, 8'h00, 1'b0, 1'b1);
    sbQ.push_back(32'h0410_544D);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (out !== exp) begin
      missCount++; $display("[TB] FAIL shape_read: got %h expected %h", out, exp);
    end
  endtask

  task automatic test_single_pixel();
    logic [31:0] exp;
    writeByte(99999, 8'h00, 1'b0, 1'b0);
    writePixel(11, 57, 8'hFF, 8'hFF, 8'hFF);
    writePixel(12, 57, 8'h10, 8'h20, 8'h30);
    writePixel(13, 57, 8'hFF, 8'hFF, 8'hFF);
    sbQ.push_back(32'h0C39_0C39);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL single_dark: got %h expected %h", boxRegs(), exp);
    end
    writePixel(20, 60, 8'h10, 8'hFF, 8'hFF);
    sbQ.push_back(32'h0C39_143C);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL red_only_dark: got %h expected %h", boxRegs(), exp);
    end
    writePixel(90, 90, 8'h80, 8'h80, 8'h80);
    sbQ.push_back(32'h0C39_143C);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL threshold_pixel: got %h expected %h", boxRegs(), exp);
    end
  endtask

  task automatic test_read_same_cycle();
    logic [31:0] exp;
    writeByte(3 * 505, 8'h00, 1'b1, 1'b0);
    writeByte(3 * 505 + 1, 8'h00, 1'b1, 1'b0);
    writeByte(3 * 505 + 2, 8'h00, 1'b1, 1'b1);
    sbQ.push_back(32'h0C39_143C);
    sbQ.push_back(32'h0505_143C);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (out !== exp) begin
      missCount++; $display("[TB] FAIL read_pre_update: got %h expected %h", out, exp);
    end
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL box_after_read: got %h expected %h", boxRegs(), exp);
    end
  endtask

  task automatic test_ignored_and_edge();
    logic [31:0] exp;
    for (int c = 0; c < 3; c++) writeByte(3 * 101 + c, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) writeByte(30000 + c, 8'h00, 1'b1, 1'b0);
    sbQ.push_back(32'h0505_143C);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL ignored_writes: got %h expected %h", boxRegs(), exp);
    end
    writePixel(99, 99, 8'h20, 8'h00, 8'h7F);
    sbQ.push_back(32'h0505_6363);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL last_pixel: got %h expected %h", boxRegs(), exp);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] exp;
    writeByte(3 * 5050, 8'h00, 1'b1, 1'b0);
    writeByte(3 * 5050 + 1, 8'h00, 1'b1, 1'b0);
    @(negedge CLOCK_50);
    reset_n = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    hex_value_index = {8'h00, 24'(3 * 5050 + 2)};
    sbQ.push_back(32'h6363_0000);
    sbQ.push_back(32'h0000_0000);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL midstream_reset_box: got %h expected %h", boxRegs(), exp);
    end
    exp = sbQ.pop_front(); vectorCount++;
    if (out !== exp) begin
      missCount++; $display("[TB] FAIL midstream_reset_out: got %h expected %h", out, exp);
    end
    writeByte(3 * 5050 + 2, 8'hFF, 1'b1, 1'b0);
    sbQ.push_back(32'h6363_0000);
    driveIdle();
    exp = sbQ.pop_front(); vectorCount++;
    if (boxRegs() !== exp) begin
      missCount++; $display("[TB] FAIL partial_pixel_dropped: got %h expected %h", boxRegs(), exp);
    end
  endtask

  initial begin
    reset_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; hex_value_index = 32'd30000;
    test_reset();
    test_triangle();
    test_restart_shape();
    test_single_pixel();
    test_read_same_cycle();
    test_ignored_and_edge();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/simple_box.md
Name: simple_box

Overview:
- Streaming bounding-box detector for a fixed-size RGB image written byte by byte over a simple indexed write bus.
- Tracks the min/max x and y of all foreground pixels; the packed box is readable on a 32-bit output.
- Sits between the host/bridge write port (index + data word) and downstream shape-analysis logic.

Parameters:
- WIDTH, 100, image width in pixels.
- HEIGHT, 100, image height in pixels.
- THRESHOLD, 128, a pixel is foreground when its smallest channel byte is < THRESHOLD.
- RESTART_INDEX, 99999, index value that re-arms (clears) the box.

Ports:
- CLOCK_50  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-high reset. The name is kept per codebase; asserted when 1.
- rd_en  in  1  read strobe; latches the packed box into out.
- wr_en  in  1  byte-write strobe.
- hex_value_index  in  32  [23:0] byte index, [31:24] byte data.
- out  out  32  {xMin[7:0], yMin[7:0], xMax[7:0], yMax[7:0]}, registered.

Behaviour:
- Byte addressing:
  - idx = hex_value_index[23:0]; pixel p = idx/3; channel c = idx%3 (0 = R, 1 = G, 2 = B).
  - x = p % WIDTH, y = p / WIDTH.
  - Valid image range is idx < WIDTH*HEIGHT*3.
- Internal registers xMin, yMin, xMax, yMax are 8-bit. They are named exactly so, for hierarchical bench access.
- Reset (reset_n = 1 at a clock edge):
  - xMin = WIDTH-1, yMin = HEIGHT-1, xMax = 0, yMax = 0.
  - out = 0; channel-min accumulator = 0xFF.
- Restart: any cycle with idx == RESTART_INDEX, independent of wr_en, applies the same clear as reset, except out. Idempotent when held.
- Accumulation, on wr_en = 1 with a valid idx:
  - c = 0: acc <= data.
  - c = 1: acc <= min(acc, data).
  - c = 2: m = min(acc, data). If m < THRESHOLD, update xMin = min(xMin, x), xMax = max(xMax, x), yMin = min(yMin, y), yMax = max(yMax, y).
  - Box registers change on the edge that samples the c = 2 write, so the box is visible one cycle after the last byte.
- Ignored writes: wr_en with an invalid idx (other than RESTART_INDEX) is ignored. wr_en = 0 leaves all state unchanged.
- Write order: bytes of one pixel must arrive in order c = 0, 1, 2. Pixels may arrive in any order; the result is order-independent per pixel.
- Read: when rd_en = 1, out <= packed current box; otherwise out holds.
  - rd_en together with a box-updating write captures the pre-update values.
- Precedence: reset > restart > write.
- Empty image (no foreground): box keeps its cleared values (xMin > xMax marks empty).
- Reset mid-stream: clears the box; a partial pixel's accumulator is discarded.
- Division by 3 and by WIDTH uses constant-divisor logic (combinational or a small pipeline). Any pipelining must keep the one-cycle-after-last-byte visibility.

Decomposition:
- Package simple_box_pkg:
  - WIDTH, HEIGHT, THRESHOLD, RESTART_INDEX defaults.
  - coord_t (logic [7:0]).
  - Packed box struct matching the out layout.
- One sub-module, box_addr_decode: idx -> {valid, x, y, c}, purely combinational.
- Top level holds the accumulator, box registers and output register.

Test Plan:
- Reset with reset_n = 1 for one cycle -> xMin = 99, yMin = 99, xMax = 0, yMax = 0, out = 0.
- Stream triangle image (30000 bytes, idx 0..29999, wr_en = 1), wait 1 cycle -> xMin = 28, yMin = 34, xMax = 69, yMax = 78.
- Drive idx = 99999 for 1 cycle, then idx = 100000, stream shape image -> xMin = 4, yMin = 16, xMax = 84, yMax = 77. Confirms no carry-over from the triangle.
- Single dark pixel: idx 3*(57*100+12)..+2 = {0x10, 0x20, 0x30} on a 0xFF background -> box (12, 57, 12, 57). A {0x10, 0xFF, 0xFF} pixel also counts; an all-{0x80} pixel does not.
- rd_en after the shape load -> out = 0x0410_544D. rd_en on the same cycle as a box-changing B write -> out shows old values.
- Writes with idx = 30000 and wr_en = 0 writes -> no change. Reset asserted mid-stream -> box cleared on the next edge.
